// File: rtl/dcache_pkg.sv
// Shared widths, FSM state codes and address helpers for the direct-mapped write-through data cache.
// Width/state macros stand in for the shared define.v and are guarded so an existing copy takes precedence.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 8
`endif
`ifndef DC_IDLE
`define DC_IDLE    2'd0
`define DC_FILL    2'd1
`define DC_CAPTURE 2'd2
`define DC_WRITE   2'd3
`endif

package dcache_pkg;
    typedef logic [`WORD_SIZE-1:0]  addr_t;
    typedef logic [`BLOCK_SIZE-1:0] block_t;

    // A line is two memory blocks.
    localparam int LINE_BYTES = 2 * `BLOCK_SIZE / `BYTE_SIZE;

    function automatic addr_t line_base(input addr_t a);
        return a & ~addr_t'(LINE_BYTES - 1);
    endfunction

    function automatic addr_t word_addr(input addr_t a);
        return {a[`WORD_SIZE-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/dcache_if.sv
// CPU load/store port and datamem block port of the data cache, bundled as one interface.
interface dcache_if;
    import dcache_pkg::*;

    // cpu_req is held with stable fields until the single-cycle cpu_ready pulse;
    // mem_out1/mem_out2 are the blocks at mem_addr and mem_addr+4 one edge after mem_addr is presented.
    logic   cpu_req;
    logic   cpu_we;
    addr_t  cpu_addr;
    block_t cpu_wdata;
    block_t cpu_rdata;
    logic   cpu_ready;
    addr_t  mem_addr;
    logic   mem_we;
    block_t mem_wdata;
    block_t mem_out1;
    block_t mem_out2;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_out1, mem_out2,
        input  cpu_rdata, cpu_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_out1, mem_out2,
        output cpu_rdata, cpu_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: one combinational read port, one line-or-block write port.
// Only the valid bits are reset; tags and data hold whatever was last written.
module dcache_array
    import dcache_pkg::*;
#(
    parameter  int LINES = 16,
    localparam int IW    = $clog2(LINES),
    localparam int TW    = `WORD_SIZE - IW - 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] rd_idx,
    output logic          rd_valid,
    output logic [TW-1:0] rd_tag,
    output block_t        rd_blk0,
    output block_t        rd_blk1,
    input  logic          wr_line,
    input  logic          wr_blk,
    input  logic [IW-1:0] wr_idx,
    input  logic [TW-1:0] wr_tag,
    input  logic          wr_sel,
    input  block_t        wr_data0,
    input  block_t        wr_data1
);
    logic [LINES-1:0] valid_q, valid_d;
    logic [TW-1:0]    tag_q  [LINES];
    block_t           blk0_q [LINES];
    block_t           blk1_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (wr_line) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) valid_q <= '0;
        else        valid_q <= valid_d;
    end

    // A block write only patches data in a line that is already valid; it never touches the tag.
    always_ff @(posedge clk) begin
        if (wr_line) begin
            tag_q[wr_idx]  <= wr_tag;
            blk0_q[wr_idx] <= wr_data0;
            blk1_q[wr_idx] <= wr_data1;
        end else if (wr_blk) begin
            if (wr_sel) blk1_q[wr_idx] <= wr_data0;
            else        blk0_q[wr_idx] <= wr_data0;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_blk0  = blk0_q[rd_idx];
    assign rd_blk1  = blk1_q[rd_idx];
endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache in front of datamem; all outputs registered.
// Defining DCACHE_STATS_EN adds hit_cnt/miss_cnt load counters.
module dcache
    import dcache_pkg::*;
#(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_if.slave     bus,
    output logic [1:0]  dbg_state
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int IW = $clog2(LINES);
    localparam int TW = `WORD_SIZE - IW - 3;

    localparam logic [1:0] S_IDLE    = `DC_IDLE;
    localparam logic [1:0] S_FILL    = `DC_FILL;
    localparam logic [1:0] S_CAPTURE = `DC_CAPTURE;
    localparam logic [1:0] S_WRITE   = `DC_WRITE;

    logic [1:0] state_q, state_d;
    block_t     cpu_rdata_q, cpu_rdata_d;
    logic       cpu_ready_q, cpu_ready_d;
    addr_t      mem_addr_q, mem_addr_d;
    logic       mem_we_q, mem_we_d;
    block_t     mem_wdata_q, mem_wdata_d;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          rd_valid, hit, accept;
    logic [TW-1:0] rd_tag;
    block_t        rd_blk0, rd_blk1;
    logic          wr_line, wr_blk;
    block_t        wr_data0, wr_data1;

    // cpu_addr is held stable for the whole transaction, so index/tag are taken from it in every state.
    assign idx    = bus.cpu_addr[IW+2:3];
    assign tag    = bus.cpu_addr[`WORD_SIZE-1:IW+3];
    assign hit    = rd_valid && (rd_tag == tag);
    assign accept = (state_q == S_IDLE) && bus.cpu_req && !cpu_ready_q;

    dcache_array #(.LINES(LINES)) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_blk0  (rd_blk0),
        .rd_blk1  (rd_blk1),
        .wr_line  (wr_line),
        .wr_blk   (wr_blk),
        .wr_idx   (idx),
        .wr_tag   (tag),
        .wr_sel   (bus.cpu_addr[2]),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1)
    );

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        wr_line     = 1'b0;
        wr_blk      = 1'b0;
        wr_data0    = bus.cpu_wdata;
        wr_data1    = bus.cpu_wdata;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.cpu_we) begin
                        mem_addr_d  = word_addr(bus.cpu_addr);
                        mem_wdata_d = bus.cpu_wdata;
                        mem_we_d    = 1'b1;
                        wr_blk      = hit;
                        state_d     = S_WRITE;
                    end else if (hit) begin
                        cpu_rdata_d = bus.cpu_addr[2] ? rd_blk1 : rd_blk0;
                        cpu_ready_d = 1'b1;
                    end else begin
                        mem_addr_d = line_base(bus.cpu_addr);
                        state_d    = S_FILL;
                    end
                end
            end
            S_FILL: state_d = S_CAPTURE;
            S_CAPTURE: begin
                wr_line     = 1'b1;
                wr_data0    = bus.mem_out1;
                wr_data1    = bus.mem_out2;
                cpu_rdata_d = bus.cpu_addr[2] ? bus.mem_out2 : bus.mem_out1;
                cpu_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_WRITE: begin
                cpu_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state     = state_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Only loads are counted, classified at the accepting edge.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && !bus.cpu_we) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule
